// File: rtl/response_tx_sm.sv
// response_tx_sm: response-packet transmitter.
// Sends RSN, RC, RDC and then RDC data words onto a 32-bit AXI-stream.
// The data words are pulled from the command machine via rd_valid/rd_ready.
// Optional feature macro: RSP_CHECKSUM_EN. When it is defined, an XOR checksum word is
// appended after the data words and carries tx_tlast.
module response_tx_sm #(
  parameter int unsigned MAX_RDC = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             send_rsp,
  input  logic [31:0]      rsp_ser_num,
  input  logic [31:0]      rsp_code,
  input  logic [CNT_W-1:0] rsp_data_count,
  input  logic [31:0]      rd_data,
  input  logic             rd_valid,
  output logic             rd_ready,
  output logic [31:0]      tx_tdata,
  output logic             tx_tvalid,
  output logic [0:3]       tx_tkeep,
  output logic             tx_tlast,
  input  logic             tx_tready,
  output logic             rsp_busy,
  output logic             rsp_done,
  output logic             rdc_clamped
);

  localparam int unsigned DATA_W = 32;
  localparam logic [CNT_W-1:0] MAX_RDC_C = CNT_W'(MAX_RDC);

`ifdef RSP_CHECKSUM_EN
  localparam int unsigned ST_W = 7;
`else
  localparam int unsigned ST_W = 6;
`endif

  // One-hot state encoding
  typedef enum logic [ST_W-1:0] {
    IDLE      = ST_W'(1 << 0),
    SEND_RSN  = ST_W'(1 << 1),
    SEND_RC   = ST_W'(1 << 2),
    SEND_RDC  = ST_W'(1 << 3),
    SEND_DATA = ST_W'(1 << 4),
`ifdef RSP_CHECKSUM_EN
    SEND_CSUM = ST_W'(1 << 5),
    DONE      = ST_W'(1 << 6)
`else
    DONE      = ST_W'(1 << 5)
`endif
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   rsn_q, rsn_d;
  logic [DATA_W-1:0]   rc_q, rc_d;
  logic [CNT_W-1:0]    rdc_q, rdc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                clamped_q, clamped_d;
  logic                last_c;
`ifdef RSP_CHECKSUM_EN
  logic [DATA_W-1:0]   csum_q, csum_d;
`endif

  // State register and latched request fields
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      rsn_q     <= '0;
      rc_q      <= '0;
      rdc_q     <= '0;
      cnt_q     <= '0;
      clamped_q <= 1'b0;
`ifdef RSP_CHECKSUM_EN
      csum_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      rsn_q     <= rsn_d;
      rc_q      <= rc_d;
      rdc_q     <= rdc_d;
      cnt_q     <= cnt_d;
      clamped_q <= clamped_d;
`ifdef RSP_CHECKSUM_EN
      csum_q    <= csum_d;
`endif
    end
  end

  // Next-state and stream outputs
  always_comb begin
    state_d   = state_q;
    rsn_d     = rsn_q;
    rc_d      = rc_q;
    rdc_d     = rdc_q;
    cnt_d     = cnt_q;
    clamped_d = clamped_q;
`ifdef RSP_CHECKSUM_EN
    csum_d    = csum_q;
`endif
    rd_ready  = 1'b0;
    tx_tdata  = '0;
    tx_tvalid = 1'b0;
    last_c    = 1'b0;
    rsp_done  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (send_rsp) begin
          rsn_d = rsp_ser_num;
          rc_d  = rsp_code;
          cnt_d = '0;
          if (rsp_data_count > MAX_RDC_C) begin
            rdc_d     = MAX_RDC_C;
            clamped_d = 1'b1;
          end else begin
            rdc_d = rsp_data_count;
          end
`ifdef RSP_CHECKSUM_EN
          csum_d = '0;
`endif
          state_d = SEND_RSN;
        end
      end
      SEND_RSN: begin
        tx_tvalid = 1'b1;
        tx_tdata  = rsn_q;
        if (tx_tready) state_d = SEND_RC;
      end
      SEND_RC: begin
        tx_tvalid = 1'b1;
        tx_tdata  = rc_q;
        if (tx_tready) state_d = SEND_RDC;
      end
      SEND_RDC: begin
        tx_tvalid = 1'b1;
        tx_tdata  = DATA_W'(rdc_q);
`ifndef RSP_CHECKSUM_EN
        last_c    = (rdc_q == '0);
`endif
        if (tx_tready) begin
          if (rdc_q == '0) begin
`ifdef RSP_CHECKSUM_EN
            state_d = SEND_CSUM;
`else
            state_d = DONE;
`endif
          end else begin
            cnt_d   = rdc_q;
            state_d = SEND_DATA;
          end
        end
      end
      SEND_DATA: begin
        tx_tvalid = rd_valid;
        tx_tdata  = rd_data;
        rd_ready  = tx_tready;
`ifndef RSP_CHECKSUM_EN
        last_c    = (cnt_q == CNT_W'(1));
`endif
        // Counter never decrements below zero
        if (rd_valid && tx_tready && (cnt_q != '0)) begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
`ifdef RSP_CHECKSUM_EN
            state_d = SEND_CSUM;
`else
            state_d = DONE;
`endif
          end
        end
      end
`ifdef RSP_CHECKSUM_EN
      SEND_CSUM: begin
        tx_tvalid = 1'b1;
        tx_tdata  = csum_q;
        last_c    = 1'b1;
        if (tx_tready) state_d = DONE;
      end
`endif
      DONE: begin
        rsp_done = 1'b1;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

`ifdef RSP_CHECKSUM_EN
    // Fold every transferred word (except the checksum itself) into the running XOR
    if (tx_tvalid && tx_tready && (state_q != SEND_CSUM)) begin
      csum_d = csum_q ^ tx_tdata;
    end
`endif
  end

  // Status and sideband outputs derived from state
  always_comb begin
    tx_tlast    = last_c & tx_tvalid;
    tx_tkeep    = {4{tx_tvalid}};
    rsp_busy    = (state_q != IDLE);
    rdc_clamped = clamped_q;
  end

endmodule

// File: tb/tb_response_tx_sm.sv
// Testbench for response_tx_sm: cycle tables, hand sequences and a randomized packet model.
module tb_response_tx_sm;

  localparam int unsigned CNT_W   = 9;
  localparam int unsigned MAX_RDC = 255;
`ifdef RSP_CHECKSUM_EN
  localparam bit CS = 1'b1;
`else
  localparam bit CS = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             send_rsp = 1'b0;
  logic [31:0]      rsp_ser_num = '0;
  logic [31:0]      rsp_code = '0;
  logic [CNT_W-1:0] rsp_data_count = '0;
  logic [31:0]      rd_data = '0;
  logic             rd_valid = 1'b0;
  logic             rd_ready;
  logic [31:0]      tx_tdata;
  logic             tx_tvalid;
  logic [0:3]       tx_tkeep;
  logic             tx_tlast;
  logic             tx_tready = 1'b1;
  logic             rsp_busy;
  logic             rsp_done;
  logic             rdc_clamped;

  response_tx_sm #(.MAX_RDC(MAX_RDC), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .send_rsp(send_rsp),
    .rsp_ser_num(rsp_ser_num), .rsp_code(rsp_code), .rsp_data_count(rsp_data_count),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .tx_tdata(tx_tdata), .tx_tvalid(tx_tvalid), .tx_tkeep(tx_tkeep), .tx_tlast(tx_tlast),
    .tx_tready(tx_tready), .rsp_busy(rsp_busy), .rsp_done(rsp_done), .rdc_clamped(rdc_clamped)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  typedef struct {
    logic             send;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      rsn;
    logic [31:0]      rc;
    logic             rdv;
    logic [31:0]      rdd;
    logic             e_valid;
    logic [31:0]      e_data;
    logic             e_last;
    logic             e_rdy;
    logic             e_busy;
    logic             e_done;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic send, input logic [CNT_W-1:0] cnt, input logic [31:0] rsn,
                     input logic [31:0] rc, input logic rdv, input logic [31:0] rdd,
                     input logic ev, input logic [31:0] ed, input logic el,
                     input logic er, input logic eb, input logic edn);
    vec_t v;
    v.send = send; v.cnt = cnt; v.rsn = rsn; v.rc = rc; v.rdv = rdv; v.rdd = rdd;
    v.e_valid = ev; v.e_data = ed; v.e_last = el; v.e_rdy = er; v.e_busy = eb; v.e_done = edn;
    vecs.push_back(v);
  endtask

  task automatic check_idle_outputs(input string name);
    check(name, 64'({tx_tvalid, tx_tdata, tx_tlast, tx_tkeep, rd_ready, rsp_busy, rsp_done,
                     rdc_clamped}), 64'(0));
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; send_rsp = 1'b0; rd_valid = 1'b0; tx_tready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset_state");
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // Drives one request and checks the whole packet against a word-list model.
  // mode: 0 = tready always 1, 1 = tready toggles every cycle, 2 = random tready.
  task automatic run_packet(input logic [31:0] rsn, input logic [31:0] rc, input int cnt,
                            input int mode, input bit gaps);
    logic [31:0] src[$];
    logic [32:0] exp_q[$];
    logic [32:0] e;
    logic [31:0] x;
    logic [31:0] d;
    logic [31:0] prev_data;
    int n, src_pos, limit;
    bit pending, prev_stall, done_seen, busy_bad;
    n = (cnt > int'(MAX_RDC)) ? int'(MAX_RDC) : cnt;
    x = rsn ^ rc ^ 32'(n);
    exp_q.push_back({1'b0, rsn});
    exp_q.push_back({1'b0, rc});
    exp_q.push_back({(n == 0) && !CS, 32'(n)});
    for (int i = 0; i < n; i++) begin
      d = $urandom();
      src.push_back(d);
      x = x ^ d;
      exp_q.push_back({(i == n - 1) && !CS, d});
    end
    if (CS) exp_q.push_back({1'b1, x});
    src_pos = 0; pending = 1'b0; prev_stall = 1'b0; done_seen = 1'b0; busy_bad = 1'b0;
    prev_data = '0;
    limit = 20 * (n + 6) + 100;

    @(posedge clk); #1;
    send_rsp = 1'b1; rsp_ser_num = rsn; rsp_code = rc; rsp_data_count = CNT_W'(cnt);
    rd_valid = 1'b0;
    tx_tready = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
    for (int cyc = 0; cyc < limit; cyc++) begin
      @(negedge clk);
      if (prev_stall) check("stall_hold", 64'({tx_tvalid, tx_tdata}), 64'({1'b1, prev_data}));
      if (tx_tvalid && tx_tready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL extra_word: got %h expected no word", tx_tdata);
        end else begin
          e = exp_q.pop_front();
          check("word", 64'({tx_tlast, tx_tkeep, tx_tdata}), 64'({e[32], 4'hf, e[31:0]}));
        end
      end
      if (rd_valid && rd_ready) src_pos++;
      pending = rd_valid && !rd_ready;
      if (cyc > 0 && !rsp_busy && !done_seen) busy_bad = 1'b1;
      if (rsp_done) done_seen = 1'b1;
      prev_stall = tx_tvalid && !tx_tready;
      prev_data = tx_tdata;
      if (done_seen) break;
      @(posedge clk); #1;
      send_rsp = 1'b0;
      case (mode)
        0:       tx_tready = 1'b1;
        1:       tx_tready = ~tx_tready;
        default: tx_tready = 1'($urandom_range(0, 1));
      endcase
      if (!pending) begin
        rd_valid = (src_pos < n) && (!gaps || ($urandom_range(0, 2) != 0));
        rd_data  = (src_pos < n) ? src[src_pos] : $urandom();
      end
    end
    check("done_seen", 64'(done_seen), 64'(1));
    check("words_left", 64'(exp_q.size()), 64'(0));
    check("data_used", 64'(src_pos), 64'(n));
    check("busy_span", 64'(busy_bad), 64'(0));
    @(posedge clk); #1;
    rd_valid = 1'b0; tx_tready = 1'b1;
  endtask

  initial begin
    vec_t v;
    logic [31:0] cs2;

    // Minimum packet: RDC=0
    add(1, 0, 32'h11, 32'h02, 0, 0,  0, 32'h0,  0, 0, 0, 0);
    add(0, 0, 32'h11, 32'h02, 0, 0,  1, 32'h11, 0, 0, 1, 0);
    add(0, 0, 32'h11, 32'h02, 0, 0,  1, 32'h02, 0, 0, 1, 0);
    add(0, 0, 32'h11, 32'h02, 0, 0,  1, 32'h00, !CS, 0, 1, 0);
    if (CS) add(0, 0, 32'h11, 32'h02, 0, 0, 1, 32'h11 ^ 32'h02, 1, 0, 1, 0);
    add(0, 0, 32'h11, 32'h02, 0, 0,  0, 32'h0,  0, 0, 1, 1);
    add(0, 0, 32'h11, 32'h02, 0, 0,  0, 32'h0,  0, 0, 0, 0);
    // RDC=3 with data always valid
    add(1, 3, 32'h100, 32'h200, 1, 32'hA,  0, 32'h0,   0, 0, 0, 0);
    add(0, 3, 32'h100, 32'h200, 1, 32'hA,  1, 32'h100, 0, 0, 1, 0);
    add(0, 3, 32'h100, 32'h200, 1, 32'hA,  1, 32'h200, 0, 0, 1, 0);
    add(0, 3, 32'h100, 32'h200, 1, 32'hA,  1, 32'h3,   0, 0, 1, 0);
    add(0, 3, 32'h100, 32'h200, 1, 32'hA,  1, 32'hA,   0, 1, 1, 0);
    add(0, 3, 32'h100, 32'h200, 1, 32'hB,  1, 32'hB,   0, 1, 1, 0);
    add(0, 3, 32'h100, 32'h200, 1, 32'hC,  1, 32'hC,   !CS, 1, 1, 0);
    cs2 = 32'h100 ^ 32'h200 ^ 32'h3 ^ 32'hA ^ 32'hB ^ 32'hC;
    if (CS) add(0, 3, 32'h100, 32'h200, 0, 32'h0, 1, cs2, 1, 0, 1, 0);
    add(0, 3, 32'h100, 32'h200, 0, 32'h0,  0, 32'h0,   0, 0, 1, 1);
    add(0, 3, 32'h100, 32'h200, 0, 32'h0,  0, 32'h0,   0, 0, 0, 0);

    do_reset();
    tx_tready = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      @(posedge clk); #1;
      send_rsp = v.send; rsp_data_count = v.cnt; rsp_ser_num = v.rsn; rsp_code = v.rc;
      rd_valid = v.rdv; rd_data = v.rdd;
      @(negedge clk);
      check($sformatf("vec%0d", i),
            64'({tx_tvalid, tx_tdata, tx_tlast, tx_tkeep, rd_ready, rsp_busy, rsp_done}),
            64'({v.e_valid, v.e_data, v.e_last, {4{v.e_valid}}, v.e_rdy, v.e_busy, v.e_done}));
    end
    @(posedge clk); #1;
    send_rsp = 1'b0; rd_valid = 1'b0;

    // RDC=2 with tready toggling and rd_valid gaps
    run_packet(32'hCAFE_0001, 32'h0000_0005, 2, 1, 1'b1);

    // Randomized packets
    for (int i = 0; i < 25; i++) begin
      run_packet($urandom(), $urandom(), int'($urandom_range(0, 8)),
                 int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end
    check("no_clamp_yet", 64'(rdc_clamped), 64'(0));

    // Oversized request is clamped to MAX_RDC
    run_packet(32'h1234_5678, 32'h9ABC_DEF0, 300, 0, 1'b0);
    check("clamp_sticky", 64'(rdc_clamped), 64'(1));

    // Second request during SEND_RC is ignored; reset in SEND_DATA aborts
    @(posedge clk); #1;
    send_rsp = 1'b1; rsp_ser_num = 32'h55; rsp_code = 32'h66; rsp_data_count = CNT_W'(4);
    tx_tready = 1'b1; rd_valid = 1'b1; rd_data = 32'hAA;
    @(posedge clk); #1;
    send_rsp = 1'b0;
    @(posedge clk); #1;
    send_rsp = 1'b1; rsp_ser_num = 32'h77; rsp_code = 32'h88; rsp_data_count = CNT_W'(1);
    @(negedge clk);
    check("rc_word", 64'(tx_tdata), 64'(32'h66));
    @(posedge clk); #1;
    send_rsp = 1'b0;
    @(negedge clk);
    check("rdc_kept", 64'({tx_tvalid, tx_tlast, tx_tdata}), 64'({1'b1, 1'b0, 32'h4}));
    @(posedge clk); #1;
    @(negedge clk);
    check("data_pass", 64'({tx_tvalid, rd_ready, tx_tdata}), 64'({1'b1, 1'b1, 32'hAA}));
    @(posedge clk); #1;
    reset = 1'b1; rd_data = 32'hBB;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_idle_outputs("abort_idle");
    @(negedge clk);
    check_idle_outputs("abort_stays_idle");
    rd_valid = 1'b0;
    run_packet(32'hF00D_0003, 32'h0000_0001, 2, 2, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
